// File: rtl/alu_muldiv_seq_pkg.sv
// Shared types for the multiply/divide sequencer: FSM states, ALU function codes
// and the bundle of ALU control lines.
package alu_muldiv_seq_pkg;

  localparam int W = 16;
  localparam logic [3:0] CNT_LAST = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CHK  = 2'd1,
    ST_ITER = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Function code layout: {saryt, p16_, S3, S2, S1, S0}
  typedef logic [5:0] alu_fn_t;

  localparam alu_fn_t FN_PASS = 6'b01_1111;
  localparam alu_fn_t FN_ADD  = 6'b11_1001;
  localparam alu_fn_t FN_SUB  = 6'b10_0110;

  typedef struct packed {
    logic saryt;
    logic p16_;
    logic sd_;
    logic sb_;
    logic sca_;
    logic scb_;
    logic saa_;
    logic sab_;
  } alu_ctl_t;

endpackage

// File: rtl/alu_muldiv_seq_fn_enc.sv
// Expands a 6-bit ALU function code into the eight control lines of the 4x181 slice.
// Both halves of the slice receive identical select lines.
module alu_fn_enc
  import alu_muldiv_seq_pkg::*;
(
  input  logic [5:0] fn_i,
  output logic [7:0] ctl_o
);

  alu_ctl_t ctl;

  always_comb begin
    ctl.saryt = fn_i[5];
    ctl.p16_  = fn_i[4];
    ctl.sd_   = ~fn_i[3];
    ctl.sca_  = ~fn_i[2];
    ctl.scb_  = ~fn_i[2];
    ctl.sb_   = ~fn_i[1];
    ctl.saa_  = ~fn_i[0];
    ctl.sab_  = ~fn_i[0];
  end

  assign ctl_o = ctl;

endmodule

// File: rtl/alu_muldiv_seq.sv
// 16-bit unsigned shift-add multiply / restoring divide sequencer that steers an
// external combinational ALU one step per clock.
module alu_muldiv_seq
  import alu_muldiv_seq_pkg::*;
#(
  parameter int DIV_EN = 1
) (
  input  logic          clk_sys,
  input  logic          rst,
  input  logic          start,
  input  logic          op,
  input  logic [W-1:0]  opa,
  input  logic [W-1:0]  opq,
  input  logic [W-1:0]  opb,
  output logic          busy,
  output logic          done,
  output logic          ovf,
  output logic [W-1:0]  res_hi,
  output logic [W-1:0]  res_lo,
  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_ac,
  input  logic [W-1:0]  alu_f,
  input  logic          alu_carry_,
  output logic          saryt,
  output logic          p16_,
  output logic          sd_,
  output logic          sb_,
  output logic          sca_,
  output logic          scb_,
  output logic          saa_,
  output logic          sab_
);

  localparam logic DIV_ON = (DIV_EN != 0);

  state_e         state_q, state_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [W-1:0]   q_q, q_d;
  logic [W-1:0]   b_q, b_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           ovf_q, ovf_d;
  logic           div_q, div_d;

  logic           carry;
  logic [W-1:0]   sh;
  logic           mul_c;
  logic           div_t;
  alu_fn_t        fn_code;
  logic [7:0]     ctl_bus;
  alu_ctl_t       ctl;

  assign carry = ~alu_carry_;
  // Divide step works on the partial remainder shifted left by one, pulling in Q's MSB.
  assign sh    = {acc_q[W-2:0], q_q[W-1]};
  assign mul_c = carry & q_q[0];
  assign div_t = acc_q[W-1] | carry;

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      q_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      div_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      div_q   <= div_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (!op)         state_d = ST_ITER;
          else if (DIV_ON) state_d = ST_CHK;
          else             state_d = ST_DONE;
        end
      end
      ST_CHK:  state_d = carry ? ST_DONE : ST_ITER;
      ST_ITER: state_d = (cnt_q == 4'd0) ? ST_DONE : ST_ITER;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    acc_d = acc_q;
    q_d   = q_q;
    b_d   = b_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    div_d = div_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          b_d   = opb;
          div_d = op;
          cnt_d = CNT_LAST;
          if (op) begin
            acc_d = opa;
            q_d   = opq;
            ovf_d = ~DIV_ON;
          end else begin
            acc_d = '0;
            q_d   = opa;
            ovf_d = 1'b0;
          end
        end
      end
      ST_CHK: begin
        // Dividend high word >= divisor (including divisor 0): quotient cannot fit.
        if (carry) ovf_d = 1'b1;
        else       cnt_d = CNT_LAST;
      end
      ST_ITER: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        if (div_q && DIV_ON) begin
          acc_d = div_t ? alu_f : sh;
          q_d   = {q_q[W-2:0], div_t};
        end else begin
          acc_d = {mul_c, alu_f[W-1:1]};
          q_d   = {alu_f[0], q_q[W-1:1]};
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    fn_code = FN_PASS;
    alu_a   = acc_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_CHK: begin
        fn_code = FN_SUB;
        busy    = 1'b1;
      end
      ST_ITER: begin
        busy = 1'b1;
        if (div_q && DIV_ON) begin
          fn_code = FN_SUB;
          alu_a   = sh;
        end else begin
          fn_code = q_q[0] ? FN_ADD : FN_PASS;
        end
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  alu_fn_enc u_fn_enc (
    .fn_i  (fn_code),
    .ctl_o (ctl_bus)
  );

  assign ctl    = ctl_bus;
  assign saryt  = ctl.saryt;
  assign p16_   = ctl.p16_;
  assign sd_    = ctl.sd_;
  assign sb_    = ctl.sb_;
  assign sca_   = ctl.sca_;
  assign scb_   = ctl.scb_;
  assign saa_   = ctl.saa_;
  assign sab_   = ctl.sab_;

  assign alu_ac = b_q;
  assign res_hi = acc_q;
  assign res_lo = q_q;
  assign ovf    = ovf_q;

endmodule
